// File: rtl/sprite_fetch.sv
// Sprite ROM address generator and pixel gate: issues ROM addresses one cycle ahead of the beam
// so the synchronous ROM output lines up with the current screen x.
module sprite_fetch #(
    parameter int WIDTH = 8,
    parameter int SPR_W = 8,
    parameter int SPR_H = 8,
    parameter int CORDW = 16,
    parameter int ADDRW = $clog2(SPR_W * SPR_H)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [WIDTH-1:0]        rom_data,
    output logic [WIDTH-1:0]        pix,
    output logic                    drawing,
    output logic                    done
);

    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic signed [CORDW-1:0] ONE = CORDW'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_POS,
        FETCH,
        LINE_DONE
    } state_t;

    state_t                  state_reg;
    logic [RW-1:0]           row_reg;
    logic [CW-1:0]           col_reg;
    logic signed [CORDW-1:0] sprx_l_reg;

    assign rom_addr = ADDRW'(row_reg) * ADDRW'(SPR_W) + ADDRW'(col_reg);

    // ROM data is only passed through while the registered drawing flag is up.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pix
            assign pix[gi] = rom_data[gi] & drawing;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            row_reg    <= '0;
            col_reg    <= '0;
            sprx_l_reg <= '0;
            drawing    <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (line && sy == spry) begin
                        row_reg    <= '0;
                        col_reg    <= '0;
                        sprx_l_reg <= sprx;
                        state_reg  <= WAIT_POS;
                    end
                end
                WAIT_POS: begin
                    // A new line before reaching the sprite consumes the row.
                    if (line) begin
                        if (row_reg == ROW_LAST) begin
                            done      <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            row_reg <= row_reg + RW'(1);
                        end
                    end else if (sx == sprx_l_reg - ONE) begin
                        drawing   <= 1'b1;
                        col_reg   <= CW'(1);
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (line) begin
                        // Line shorter than the sprite: abandon the row rather than hang.
                        drawing <= 1'b0;
                        col_reg <= '0;
                        if (row_reg == ROW_LAST) begin
                            done      <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            row_reg   <= row_reg + RW'(1);
                            state_reg <= WAIT_POS;
                        end
                    end else if (col_reg == COL_LAST) begin
                        col_reg   <= '0;
                        state_reg <= LINE_DONE;
                    end else begin
                        col_reg <= col_reg + CW'(1);
                    end
                end
                LINE_DONE: begin
                    drawing <= 1'b0;
                    if (row_reg == ROW_LAST) begin
                        done      <= 1'b1;
                        state_reg <= IDLE;
                    end else if (line) begin
                        row_reg   <= row_reg + RW'(1);
                        state_reg <= WAIT_POS;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Bench for sprite_fetch: directed frames with checkpoint vectors plus randomized frames
// compared against a row/pixel-level model of the sprite on screen.
module tb_sprite_fetch;

    localparam int SX_MIN = -20;
    localparam int SX_MAX = 139;
    localparam int SY_MIN = 45;
    localparam int SY_MAX = 62;

    logic               clk = 1'b0;
    logic               rst;
    logic               line;
    logic signed [15:0] sx, sy, sprx, spry;
    logic [5:0]         rom_addr;
    logic [7:0]         rom_data;
    logic [7:0]         pix;
    logic               drawing;
    logic               done;

    sprite_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .line     (line),
        .sx       (sx),
        .sy       (sy),
        .sprx     (sprx),
        .spry     (spry),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .pix      (pix),
        .drawing  (drawing),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM holding ROM[a] = a.
    always @(posedge clk) rom_data <= 8'(rom_addr);

    typedef struct {
        int fid;
        int sy;
        int sx;
        bit drw;
        int pix;
        bit dn;
        bit chka;
        int addr;
    } vec_t;

    vec_t vecs[$];

    int n_total = 0;
    int n_pass  = 0;
    int cur_fid, cur_y, cur_x;

    // Model: a sprite is either inactive or positioned at mx with the current row counted in lines.
    bit active    = 1'b0;
    int row       = 0;
    int mx        = 0;
    bit done_pend = 1'b0;

    task automatic add(input int f, input int y, input int x, input bit d, input int p,
                       input bit dn, input bit ca, input int a);
        vec_t v;
        v.fid = f; v.sy = y; v.sx = x; v.drw = d; v.pix = p; v.dn = dn; v.chka = ca; v.addr = a;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (frame %0d line %0d sx %0d)",
                      nm, act, exp, cur_fid, cur_y, cur_x);
    endtask

    task automatic cycle(input int fid, input int y, input int x, input bit ln, input bit rs);
        int exp_draw, exp_pix, exp_done, exp_addr;
        bit chk_addr;
        cur_fid = fid; cur_y = y; cur_x = x;
        rst  = 1'b0;
        sy   = 16'(y);
        sx   = 16'(x);
        line = ln;

        exp_done  = int'(done_pend);
        done_pend = 1'b0;
        if (ln) begin
            if (active) begin
                row++;
                if (row == 8) begin
                    active    = 1'b0;
                    done_pend = 1'b1;
                end
            end else if (y == int'(spry)) begin
                active = 1'b1;
                row    = 0;
                mx     = int'(sprx);
            end
        end
        exp_draw = (active && x >= mx && x <= mx + 7) ? 1 : 0;
        exp_pix  = (exp_draw != 0) ? row * 8 + x - mx : 0;
        chk_addr = active && x >= mx - 1 && x <= mx + 6;
        exp_addr = row * 8 + x - mx + 1;
        if (active && row == 7 && x == mx + 7) begin
            active    = 1'b0;
            done_pend = 1'b1;
        end

        if (rs) begin
            #1 rst = 1'b1;
            #1;
            check("rst_draw", int'(drawing), 0);
            check("rst_pix", int'(pix), 0);
            check("rst_done", int'(done), 0);
            check("rst_addr", int'(rom_addr), 0);
            active    = 1'b0;
            done_pend = 1'b0;
            exp_draw  = 0;
            exp_pix   = 0;
            exp_done  = 0;
            chk_addr  = 1'b1;
            exp_addr  = 0;
        end

        @(negedge clk);
        check("cyc{draw,pix,done}", int'({drawing, pix, done}), exp_draw * 512 + exp_pix * 2 + exp_done);
        if (chk_addr) check("addr", int'(rom_addr), exp_addr);
        foreach (vecs[i]) begin
            if (vecs[i].fid == fid && vecs[i].sy == y && vecs[i].sx == x) begin
                check("vec_draw", int'(drawing), int'(vecs[i].drw));
                check("vec_pix", int'(pix), vecs[i].pix);
                check("vec_done", int'(done), int'(vecs[i].dn));
                if (vecs[i].chka) check("vec_addr", int'(rom_addr), vecs[i].addr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int fid, input int px, input int py, input int chg_line,
                             input int cx, input int cy, input int rst_line, input int rst_sx);
        $display("frame %0d: sprx %0d spry %0d, move at line %0d to (%0d,%0d), reset at line %0d sx %0d",
                 fid, px, py, chg_line, cx, cy, rst_line, rst_sx);
        sprx = 16'(px);
        spry = 16'(py);
        for (int y = SY_MIN; y <= SY_MAX; y++) begin
            for (int x = SX_MIN; x <= SX_MAX; x++) begin
                if (y == chg_line && x == SX_MIN) begin
                    sprx = 16'(cx);
                    spry = 16'(cy);
                end
                cycle(fid, y, x, x == SX_MIN, y == rst_line && x == rst_sx);
            end
        end
    endtask

    initial begin
        // frame 0: sprx 100, spry 50
        add(0, 52, 103, 1'b1, 8'h13, 1'b0, 1'b0, 0);
        add(0, 57, 107, 1'b1, 8'h3F, 1'b0, 1'b0, 0);
        add(0, 57, 108, 1'b0, 0,     1'b1, 1'b0, 0);
        add(0, 57, 109, 1'b0, 0,     1'b0, 1'b0, 0);
        add(0, 49, 100, 1'b0, 0,     1'b0, 1'b0, 0);
        add(0, 58, 100, 1'b0, 0,     1'b0, 1'b0, 0);
        add(0, 50, 100, 1'b1, 0,     1'b0, 1'b0, 0);
        add(0, 50, 99,  1'b0, 0,     1'b0, 1'b1, 8'h00);
        add(0, 52, 99,  1'b0, 0,     1'b0, 1'b1, 8'h10);
        add(0, 52, 100, 1'b1, 8'h10, 1'b0, 1'b1, 8'h11);
        add(0, 50, 108, 1'b0, 0,     1'b0, 1'b0, 0);
        // frame 1: position moved on line 53, old position keeps drawing
        add(1, 53, 100, 1'b1, 8'h18, 1'b0, 1'b0, 0);
        add(1, 55, 104, 1'b1, 8'h2C, 1'b0, 1'b0, 0);
        add(1, 57, 107, 1'b1, 8'h3F, 1'b0, 1'b0, 0);
        add(1, 57, 108, 1'b0, 0,     1'b1, 1'b0, 0);
        // frame 2: new position (30,47)
        add(2, 47, 30,  1'b1, 0,     1'b0, 1'b0, 0);
        add(2, 48, 31,  1'b1, 9,     1'b0, 1'b0, 0);
        add(2, 50, 100, 1'b0, 0,     1'b0, 1'b0, 0);
        // frame 3: reset at line 53 sx 104
        add(3, 53, 103, 1'b1, 8'h1B, 1'b0, 1'b0, 0);
        add(3, 53, 104, 1'b0, 0,     1'b0, 1'b0, 0);
        add(3, 55, 100, 1'b0, 0,     1'b0, 1'b0, 0);
        // frame 4: recovers normally
        add(4, 50, 100, 1'b1, 0,     1'b0, 1'b0, 0);
        add(4, 51, 101, 1'b1, 9,     1'b0, 1'b0, 0);
        // frame 5: sprx 0
        add(5, 50, -1,  1'b0, 0,     1'b0, 1'b1, 0);
        add(5, 50, 0,   1'b1, 0,     1'b0, 1'b1, 1);
        add(5, 50, 7,   1'b1, 7,     1'b0, 1'b0, 0);
        add(5, 50, 8,   1'b0, 0,     1'b0, 1'b0, 0);
        // frame 6: sprx -4
        add(6, 51, -5,  1'b0, 0,     1'b0, 1'b1, 8);
        add(6, 51, -4,  1'b1, 8,     1'b0, 1'b0, 0);
        add(6, 51, 3,   1'b1, 15,    1'b0, 1'b0, 0);
        // frame 7: sprx never reached, rows skipped
        add(7, 55, 0,   1'b0, 0,     1'b0, 1'b0, 0);
        add(7, 57, -19, 1'b0, 0,     1'b0, 1'b0, 0);
        add(7, 58, -19, 1'b0, 0,     1'b1, 1'b0, 0);
        add(7, 58, -18, 1'b0, 0,     1'b0, 1'b0, 0);

        rst = 1'b1; line = 1'b0; sx = '0; sy = '0; sprx = '0; spry = '0;
        cur_fid = -1; cur_y = 0; cur_x = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_draw", int'(drawing), 0);
        check("reset_done", int'(done), 0);
        check("reset_pix", int'(pix), 0);
        check("reset_addr", int'(rom_addr), 0);

        run_frame(0, 100, 50, -1000, 0, 0, -1000, 0);
        run_frame(1, 100, 50, 53, 30, 47, -1000, 0);
        run_frame(2, 30, 47, -1000, 0, 0, -1000, 0);
        run_frame(3, 100, 50, -1000, 0, 0, 53, 104);
        run_frame(4, 100, 50, -1000, 0, 0, -1000, 0);
        run_frame(5, 0, 50, -1000, 0, 0, -1000, 0);
        run_frame(6, -4, 50, -1000, 0, 0, -1000, 0);
        run_frame(7, 500, 50, -1000, 0, 0, -1000, 0);

        for (int f = 8; f < 20; f++) begin
            int px, py, cl, cx, cy, rl, rx;
            px = ($urandom_range(0, 4) == 0) ? 500 : int'($urandom_range(0, 147)) - 15;
            py = 46 + int'($urandom_range(0, 7));
            cl = ($urandom_range(0, 1) == 1) ? SY_MIN + int'($urandom_range(0, 17)) : -1000;
            cx = ($urandom_range(0, 4) == 0) ? 500 : int'($urandom_range(0, 147)) - 15;
            cy = 46 + int'($urandom_range(0, 7));
            rl = ($urandom_range(0, 3) == 0) ? SY_MIN + int'($urandom_range(0, 17)) : -1000;
            rx = int'($urandom_range(0, 159)) + SX_MIN;
            run_frame(f, px, py, cl, cx, cy, rl, rx);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
